// File: rtl/program_sequencer_pkg.sv
// Shared types and constants for the program sequencer: FSM state and mode
// encodings, opcode field geometry and the default HALT opcode.
package program_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_e;

    localparam int          OPCODE_W        = 4;
    localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;

    function automatic logic is_halt(input logic [OPCODE_W-1:0] opcode,
                                     input logic [OPCODE_W-1:0] halt_op);
        return (opcode == halt_op);
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Processor / output-port bundle of the program sequencer. The sequencer is
// the master; the processor and the output consumer sit on the slave side.
interface program_sequencer_if #(
    parameter int ADDR_W  = 3,
    parameter int INSTR_W = 32
);
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               exec_done;
    logic               jump_valid;
    logic [ADDR_W-1:0]  jump_addr;
    logic [31:0]        result;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output instr, instr_valid, out_data, out_valid,
        input  exec_done, jump_valid, jump_addr, result, out_ready
    );

    modport slave (
        input  instr, instr_valid, out_data, out_valid,
        output exec_done, jump_valid, jump_addr, result, out_ready
    );
endinterface

// File: rtl/program_sequencer_pc_counter.sv
// Program counter: holds the ROM address, advancing to the jump target or to
// pc+1 (wrapping at 2^ADDR_W) when the sequencer retires an instruction.
module pc_counter #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc
);
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;

    // Jump mux / natural-width increment
    always_comb begin
        if (jump_valid) begin
            pc_nxt_s = jump_addr;
        end else begin
            pc_nxt_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= {ADDR_W{1'b0}};
        end else if (advance) begin
            pc_r <= pc_nxt_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;
endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute controller: drives program_rom from the PC, hands instructions
// to the processor and returns result[7:0] over a valid/ready port.
// Optional breakpoint support is enabled with `define BREAKPOINT_EN.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int         ADDR_W      = 3,
    parameter int         INSTR_W     = 32,
    parameter logic [3:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    input  logic                halt_req,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_data,
    program_sequencer_if.master bus,
`ifdef BREAKPOINT_EN
    input  logic                bp_en,
    input  logic [ADDR_W-1:0]   bp_addr,
    output logic                bp_hit,
`endif
    output logic                busy,
    output logic                halted
);
    state_e             state_r, state_nxt_s;
    mode_e              mode_r, mode_nxt_s;
    logic               halt_flag_r, halt_flag_nxt_s;
    logic [INSTR_W-1:0] instr_r, instr_nxt_s;
    logic               instr_valid_r, instr_valid_nxt_s;
    logic [7:0]         out_data_r, out_data_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic               halted_r, halted_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               pc_adv_s;
    logic               stop_req_s;
    logic               bp_stop_s;
    logic [ADDR_W-1:0]  pc_s;
    logic               unused_result_s;

    pc_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (pc_adv_s),
        .jump_valid (bus.jump_valid),
        .jump_addr  (bus.jump_addr),
        .pc         (pc_s)
    );

    assign stop_req_s      = halt_flag_r | halt_req;
    assign unused_result_s = ^bus.result[31:8];

`ifdef BREAKPOINT_EN
    logic bp_hit_r, bp_hit_nxt_s;

    // pc already holds the next address while in OUTPUT
    assign bp_stop_s = (mode_r == MODE_RUN) && bp_en && (pc_s == bp_addr);

    // Breakpoint flag: set on a breakpoint stop, cleared when run/step is accepted
    always_comb begin
        if ((state_r == ST_IDLE) && (run || step)) begin
            bp_hit_nxt_s = 1'b0;
        end else if ((state_r == ST_OUTPUT) && bus.out_ready && !stop_req_s && bp_stop_s) begin
            bp_hit_nxt_s = 1'b1;
        end else begin
            bp_hit_nxt_s = bp_hit_r;
        end
    end

    // Breakpoint flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_hit_r <= 1'b0;
        end else begin
            bp_hit_r <= bp_hit_nxt_s;
        end
    end

    assign bp_hit = bp_hit_r;
`else
    assign bp_stop_s = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s       = state_r;
        mode_nxt_s        = mode_r;
        halt_flag_nxt_s   = halt_flag_r;
        instr_nxt_s       = instr_r;
        instr_valid_nxt_s = 1'b0;
        out_data_nxt_s    = out_data_r;
        out_valid_nxt_s   = out_valid_r;
        halted_nxt_s      = halted_r;
        pc_adv_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                halt_flag_nxt_s = 1'b0;
                if (run) begin
                    state_nxt_s = ST_FETCH;
                    mode_nxt_s  = MODE_RUN;
                end else if (step) begin
                    state_nxt_s = ST_FETCH;
                    mode_nxt_s  = MODE_STEP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                instr_nxt_s     = rom_data;
                halt_flag_nxt_s = stop_req_s;
                if (is_halt(rom_data[INSTR_W-1 -: OPCODE_W], HALT_OPCODE)) begin
                    state_nxt_s  = ST_HALTED;
                    halted_nxt_s = 1'b1;
                end else begin
                    state_nxt_s       = ST_EXEC;
                    instr_valid_nxt_s = 1'b1;
                end
            end
            ST_EXEC: begin
                halt_flag_nxt_s = stop_req_s;
                if (bus.exec_done) begin
                    out_data_nxt_s  = bus.result[7:0];
                    out_valid_nxt_s = 1'b1;
                    pc_adv_s        = 1'b1;
                    state_nxt_s     = ST_OUTPUT;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    halt_flag_nxt_s = 1'b0;
                    if (stop_req_s || (mode_r == MODE_STEP) || bp_stop_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    halt_flag_nxt_s = stop_req_s;
                    state_nxt_s     = ST_OUTPUT;
                end
            end
            ST_HALTED: begin
                state_nxt_s = ST_HALTED;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_EXEC) ||
                     (state_nxt_s == ST_OUTPUT);
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            mode_r        <= MODE_RUN;
            halt_flag_r   <= 1'b0;
            instr_r       <= {INSTR_W{1'b0}};
            instr_valid_r <= 1'b0;
            out_data_r    <= 8'h00;
            out_valid_r   <= 1'b0;
            halted_r      <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            mode_r        <= mode_nxt_s;
            halt_flag_r   <= halt_flag_nxt_s;
            instr_r       <= instr_nxt_s;
            instr_valid_r <= instr_valid_nxt_s;
            out_data_r    <= out_data_nxt_s;
            out_valid_r   <= out_valid_nxt_s;
            halted_r      <= halted_nxt_s;
            busy_r        <= busy_nxt_s;
        end
    end

    assign rom_addr        = pc_s;
    assign bus.instr       = instr_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_valid   = out_valid_r;
    assign busy            = busy_r;
    assign halted          = halted_r;
endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: step-mode vector table plus
// hand-written run / wrap / jump / halt / reset / breakpoint sequences.
module tb_program_sequencer;
    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        halt_req;
    logic [2:0]  rom_addr;
    logic [31:0] rom_data;
    logic        busy;
    logic        halted;
`ifdef BREAKPOINT_EN
    logic        bp_en;
    logic [2:0]  bp_addr;
    logic        bp_hit;
`endif

    logic [31:0] rom [0:7];
    logic [7:0]  sb [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          iv_count = 0;

    typedef struct {
        logic [2:0]  pc;
        logic [31:0] instr;
        int          delay;
        logic        jv;
        logic [2:0]  ja;
        logic [31:0] res;
        int          rdly;
        logic [2:0]  exp_next;
    } vec_t;

    vec_t       vecs [4];
    logic [2:0] run_seq [4];

    program_sequencer_if #(.ADDR_W(3), .INSTR_W(32)) bus ();

    program_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .step     (step),
        .halt_req (halt_req),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .bus      (bus),
`ifdef BREAKPOINT_EN
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .bp_hit   (bp_hit),
`endif
        .busy     (busy),
        .halted   (halted)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.instr_valid) iv_count++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic pulse(input bit is_run);
        if (is_run) run = 1'b1; else step = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        step = 1'b0;
    endtask

    task automatic wait_iv();
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.instr_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("instr_valid_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic do_exec(input int dly, input logic jv, input logic [2:0] ja, input logic [31:0] res);
        repeat (dly) @(negedge clk);
        bus.exec_done  = 1'b1;
        bus.jump_valid = jv;
        bus.jump_addr  = ja;
        bus.result     = res;
        sb.push_back(res[7:0]);
        @(negedge clk);
        bus.exec_done  = 1'b0;
        bus.jump_valid = 1'b0;
    endtask

    task automatic wait_output(input int rdly, input bit keep);
        bit         got = 1'b0;
        logic [7:0] exp;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("out_valid_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        exp = sb.pop_front();
        for (int i = 0; i < rdly; i++) begin
            chk("out_valid_hold", {31'd0, bus.out_valid}, 32'd1);
            chk("out_data_hold", {24'd0, bus.out_data}, {24'd0, exp});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        chk("out_data", {24'd0, bus.out_data}, {24'd0, exp});
        @(negedge clk);
        if (!keep) bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    initial begin
        int base;
        vecs[0] = '{pc: 3'd0, instr: 32'h1000_0000, delay: 3, jv: 1'b0, ja: 3'd0,
                    res: 32'h0000_01A5, rdly: 0, exp_next: 3'd1};
        vecs[1] = '{pc: 3'd1, instr: 32'h2000_0011, delay: 0, jv: 1'b0, ja: 3'd7,
                    res: 32'h0000_003C, rdly: 1, exp_next: 3'd2};
        vecs[2] = '{pc: 3'd2, instr: 32'h3000_0022, delay: 1, jv: 1'b1, ja: 3'd5,
                    res: 32'h0001_0077, rdly: 0, exp_next: 3'd5};
        vecs[3] = '{pc: 3'd5, instr: 32'h4000_0055, delay: 0, jv: 1'b0, ja: 3'd0,
                    res: 32'hDEAD_BEFF, rdly: 2, exp_next: 3'd6};
        run_seq = '{3'd6, 3'd7, 3'd0, 3'd1};
        for (int i = 0; i < 8; i++) rom[i] = 32'h0100_0000 + 32'(i);

        rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        bus.exec_done = 1'b0; bus.jump_valid = 1'b0; bus.jump_addr = 3'd0;
        bus.result = 32'd0; bus.out_ready = 1'b0;
`ifdef BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = 3'd0;
`endif
        #1;
        chk("rst_rom_addr", {29'd0, rom_addr}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
`ifdef BREAKPOINT_EN
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Step-mode vector table
        for (int v = 0; v < 4; v++) begin
            base = iv_count;
            rom[vecs[v].pc] = vecs[v].instr;
            chk("tbl_pc_before", {29'd0, rom_addr}, {29'd0, vecs[v].pc});
            pulse(1'b0);
            wait_iv();
            chk("tbl_instr", bus.instr, vecs[v].instr);
            chk("tbl_busy_exec", {31'd0, busy}, 32'd1);
            do_exec(vecs[v].delay, vecs[v].jv, vecs[v].ja, vecs[v].res);
            wait_output(vecs[v].rdly, 1'b0);
            chk("tbl_busy_idle", {31'd0, busy}, 32'd0);
            chk("tbl_next_pc", {29'd0, rom_addr}, {29'd0, vecs[v].exp_next});
            chk("tbl_out_valid_clr", {31'd0, bus.out_valid}, 32'd0);
            chk("tbl_one_instr_valid", 32'(iv_count - base), 32'd1);
        end

        // Run from pc=6 with wrap, then HALT opcode at address 2
        rom[6] = 32'h5000_0066; rom[7] = 32'h6000_0077;
        rom[0] = 32'h7000_0000; rom[1] = 32'h8000_0011; rom[2] = 32'hF000_0000;
        base = iv_count;
        bus.out_ready = 1'b1;
        pulse(1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_iv();
            chk("run_rom_addr", {29'd0, rom_addr}, {29'd0, run_seq[k]});
            chk("run_instr", bus.instr, rom[run_seq[k]]);
            do_exec(k, 1'b0, 3'd0, 32'h0000_0010 + 32'(k) * 32'h0000_0011);
            wait_output(0, 1'b1);
        end
        repeat (3) @(negedge clk);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_rom_addr", {29'd0, rom_addr}, 32'd2);
        chk("halt_instr", bus.instr, 32'hF000_0000);
        chk("halt_iv_count", 32'(iv_count - base), 32'd4);
        pulse(1'b1);
        pulse(1'b0);
        halt_req = 1'b1;
        repeat (4) @(negedge clk);
        halt_req = 1'b0;
        chk("halted_sticky", {31'd0, halted}, 32'd1);
        chk("halted_busy", {31'd0, busy}, 32'd0);
        chk("halted_rom_addr", {29'd0, rom_addr}, 32'd2);
        chk("halted_no_iv", 32'(iv_count - base), 32'd4);
        bus.out_ready = 1'b0;

        // halt_req during EXEC with a stalled consumer
        do_reset();
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        rom[0] = 32'h1234_5678;
        base = iv_count;
        pulse(1'b1);
        wait_iv();
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        do_exec(0, 1'b0, 3'd0, 32'h0000_00C3);
        wait_output(4, 1'b0);
        chk("hreq_busy", {31'd0, busy}, 32'd0);
        chk("hreq_rom_addr", {29'd0, rom_addr}, 32'd1);
        repeat (3) @(negedge clk);
        chk("hreq_stays_idle", {31'd0, busy}, 32'd0);
        chk("hreq_iv_count", 32'(iv_count - base), 32'd1);

        // Asynchronous reset while an output is pending
        rom[1] = 32'h2222_2222;
        pulse(1'b1);
        wait_iv();
        do_exec(2, 1'b0, 3'd0, 32'h0000_0099);
        repeat (2) @(negedge clk);
        chk("pend_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pend_out_data", {24'd0, bus.out_data}, 32'h99);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_out_data", {24'd0, bus.out_data}, 32'd0);
        chk("arst_instr", bus.instr, 32'd0);
        chk("arst_rom_addr", {29'd0, rom_addr}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef BREAKPOINT_EN
        // Breakpoint at address 3 in run mode
        rom[0] = 32'h1000_0000; rom[1] = 32'h1000_0001; rom[2] = 32'h1000_0002;
        bp_en = 1'b1; bp_addr = 3'd3;
        base = iv_count;
        bus.out_ready = 1'b1;
        pulse(1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_iv();
            do_exec(0, 1'b0, 3'd0, 32'h0000_0040 + 32'(k));
            wait_output(0, 1'b1);
        end
        repeat (2) @(negedge clk);
        chk("bp_busy", {31'd0, busy}, 32'd0);
        chk("bp_rom_addr", {29'd0, rom_addr}, 32'd3);
        chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
        chk("bp_iv_count", 32'(iv_count - base), 32'd3);
        pulse(1'b0);
        chk("bp_hit_clr", {31'd0, bp_hit}, 32'd0);
        wait_iv();
        do_exec(0, 1'b0, 3'd0, 32'h0000_0055);
        wait_output(0, 1'b0);
        chk("bp_step_no_hit", {31'd0, bp_hit}, 32'd0);
        chk("bp_step_rom_addr", {29'd0, rom_addr}, 32'd4);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
